// File: rtl/adc_avg_filter.sv
// Eight-channel boxcar averager sharing one adder across channels; publishes floored averages.
// Build option ADC_AVG_PEAK_EN adds per-channel peak-hold registers with CLR_PEAK / SEL_PEAK.
module adc_avg_filter #(
    parameter int DATA_W   = 12,
    parameter int LOG2_AVG = 4,
    parameter int TICK_DIV = 50000
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
`ifdef ADC_AVG_PEAK_EN
    input  logic              i_clr_peak,
    output logic [DATA_W-1:0] o_sel_peak,
`endif
    input  logic [DATA_W-1:0] i_ch0,
    input  logic [DATA_W-1:0] i_ch1,
    input  logic [DATA_W-1:0] i_ch2,
    input  logic [DATA_W-1:0] i_ch3,
    input  logic [DATA_W-1:0] i_ch4,
    input  logic [DATA_W-1:0] i_ch5,
    input  logic [DATA_W-1:0] i_ch6,
    input  logic [DATA_W-1:0] i_ch7,
    input  logic [2:0]        i_sel,
    output logic [DATA_W-1:0] o_avg0,
    output logic [DATA_W-1:0] o_avg1,
    output logic [DATA_W-1:0] o_avg2,
    output logic [DATA_W-1:0] o_avg3,
    output logic [DATA_W-1:0] o_avg4,
    output logic [DATA_W-1:0] o_avg5,
    output logic [DATA_W-1:0] o_avg6,
    output logic [DATA_W-1:0] o_avg7,
    output logic              o_avg_valid,
    output logic [DATA_W-1:0] o_sel_avg
);

    // state   | meaning
    // S_IDLE  | waiting for a sample tick
    // S_ACCUM | adding channel r_ch_idx (0..7), one per cycle
    // S_DONE  | one cycle after a final sample, drives o_avg_valid
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t                r_state;
    state_t                w_next;
    logic [DIV_W-1:0]      r_div;
    logic                  w_tick;
    logic [2:0]            r_ch_idx;
    logic [LOG2_AVG-1:0]   r_samp;
    logic [ACC_W-1:0]      r_acc [8];
    logic [DATA_W-1:0]     r_avg [8];
    logic [DATA_W-1:0]     r_sel_avg;
    logic [DATA_W-1:0]     w_ch  [8];
    logic [DATA_W-1:0]     w_ch_sel;
    logic [ACC_W-1:0]      w_sum;
    logic [DATA_W-1:0]     w_avg_new;
    logic                  w_final;
    logic                  w_accum;

    assign w_ch[0] = i_ch0;
    assign w_ch[1] = i_ch1;
    assign w_ch[2] = i_ch2;
    assign w_ch[3] = i_ch3;
    assign w_ch[4] = i_ch4;
    assign w_ch[5] = i_ch5;
    assign w_ch[6] = i_ch6;
    assign w_ch[7] = i_ch7;

    assign w_tick    = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_final   = &r_samp;
    assign w_ch_sel  = w_ch[r_ch_idx];
    assign w_sum     = r_acc[r_ch_idx] + ACC_W'(w_ch_sel);
    // Dropping the low LOG2_AVG bits is the floored divide.
    assign w_avg_new = w_sum[ACC_W-1:LOG2_AVG];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accum     = 1'b0;
        o_avg_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) w_next = S_ACCUM;
            end
            S_ACCUM: begin
                w_accum = 1'b1;
                if (r_ch_idx == 3'd7) w_next = w_final ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                o_avg_valid = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ch_idx  <= '0;
            r_samp    <= '0;
            r_sel_avg <= '0;
            for (int k = 0; k < 8; k++) begin
                r_acc[k] <= '0;
                r_avg[k] <= '0;
            end
        end else begin
            r_sel_avg <= r_avg[i_sel];
            if (w_accum) begin
                r_ch_idx <= r_ch_idx + 3'd1;
                if (r_ch_idx == 3'd7) r_samp <= r_samp + 1'b1;
                if (w_final) begin
                    r_avg[r_ch_idx] <= w_avg_new;
                    r_acc[r_ch_idx] <= '0;
                end else begin
                    r_acc[r_ch_idx] <= w_sum;
                end
            end
        end
    end

    assign o_avg0    = r_avg[0];
    assign o_avg1    = r_avg[1];
    assign o_avg2    = r_avg[2];
    assign o_avg3    = r_avg[3];
    assign o_avg4    = r_avg[4];
    assign o_avg5    = r_avg[5];
    assign o_avg6    = r_avg[6];
    assign o_avg7    = r_avg[7];
    assign o_sel_avg = r_sel_avg;

`ifdef ADC_AVG_PEAK_EN
    logic [DATA_W-1:0] r_peak [8];
    logic [DATA_W-1:0] r_sel_peak;

    // A clear that lands on an update takes the new average, not the stale one.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sel_peak <= '0;
            for (int k = 0; k < 8; k++) r_peak[k] <= '0;
        end else begin
            r_sel_peak <= r_peak[i_sel];
            for (int k = 0; k < 8; k++) begin
                if (w_accum && w_final && (r_ch_idx == 3'(k))) begin
                    if (i_clr_peak || (w_avg_new > r_peak[k])) r_peak[k] <= w_avg_new;
                end else if (i_clr_peak) begin
                    r_peak[k] <= r_avg[k];
                end
            end
        end
    end

    assign o_sel_peak = r_sel_peak;
`else
    // Peak tracking is not built in this configuration.
`endif

endmodule
